// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: multi-channel duty fade sequencer for a bank of pwm instances.
// Each prescaler tick starts one sweep that moves every channel's duty one step
// toward its target using a single time-shared adder/comparator.
// Optional build macro PWM_FADE_SYNC_UPDATE_EN: adds a shadow bank and an UPDATE
// state so that all channels publish new duties together. Without it, each channel's
// duty comes straight from its working register.
module pwm_fade_ctrl #(
  parameter int unsigned NumChannels  = 4,
  parameter int unsigned CtrSize      = 8,
  parameter int unsigned PrescaleSize = 16
) (
  input  logic                             clk_sys_i,
  input  logic                             rst_sys_i,
  input  logic [PrescaleSize-1:0]          rate_i,
  input  logic                             cfg_valid_i,
  output logic                             cfg_ready_o,
  input  logic [$clog2(NumChannels)-1:0]   cfg_chan_i,
  input  logic [CtrSize-1:0]               cfg_target_i,
  input  logic [CtrSize-1:0]               cfg_step_i,
  output logic [NumChannels*CtrSize-1:0]   pulse_width_o,
  output logic                             update_o,
  output logic [NumChannels-1:0]           busy_o,
  output logic [NumChannels-1:0]           done_o
);

  localparam int unsigned ChanW = $clog2(NumChannels);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSweep  = 2'd1;
`ifdef PWM_FADE_SYNC_UPDATE_EN
  localparam logic [1:0] StUpdate = 2'd2;
`endif

  logic [1:0]                            state_q, state_d;
  logic [ChanW-1:0]                      idx_q, idx_d;
  logic [PrescaleSize-1:0]               presc_q;
  logic                                  pending_q, pending_d;
  logic [NumChannels-1:0][CtrSize-1:0]   tgt_q, tgt_d;
  logic [NumChannels-1:0][CtrSize-1:0]   step_q, step_d;
  logic [NumChannels-1:0][CtrSize-1:0]   cur_q, cur_d;
  logic [NumChannels-1:0]                done_acc_q, done_acc_d;
  logic [NumChannels-1:0]                done_q, done_d;
  logic [NumChannels-1:0]                busy_q, busy_d;
  logic                                  update_q, update_d;
  logic                                  ready_q;

  logic                                  tick_c;
  logic                                  chan_ok_c;
  logic                                  last_c;
  logic [CtrSize-1:0]                    sel_cur_c, sel_tgt_c, sel_step_c, step_res_c;
  logic [CtrSize:0]                      sum_c, diff_c;

  assign tick_c    = (presc_q >= rate_i);
  assign chan_ok_c = (32'(cfg_chan_i) < NumChannels);
  assign last_c    = (idx_q == ChanW'(NumChannels - 1));

  // Prescaler: free-running count, cleared on each tick.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) presc_q <= '0;
    else if (tick_c) presc_q <= '0;
    else presc_q <= presc_q + PrescaleSize'(1);
  end

  // Shared step unit: one bit of headroom so the result clamps instead of wrapping.
  always_comb begin
    sel_cur_c  = cur_q[idx_q];
    sel_tgt_c  = tgt_q[idx_q];
    sel_step_c = step_q[idx_q];
    sum_c      = {1'b0, sel_cur_c} + {1'b0, sel_step_c};
    diff_c     = {1'b0, sel_cur_c} - {1'b0, sel_step_c};
    step_res_c = sel_cur_c;
    if (sel_step_c == '0) begin
      step_res_c = sel_tgt_c;
    end else if (sel_cur_c < sel_tgt_c) begin
      step_res_c = (sum_c > {1'b0, sel_tgt_c}) ? sel_tgt_c : sum_c[CtrSize-1:0];
    end else if (sel_cur_c > sel_tgt_c) begin
      step_res_c = (diff_c[CtrSize] || (diff_c[CtrSize-1:0] < sel_tgt_c))
                   ? sel_tgt_c : diff_c[CtrSize-1:0];
    end
  end

  // Sweep FSM next-state, config writes and per-channel register updates.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    tgt_d      = tgt_q;
    step_d     = step_q;
    cur_d      = cur_q;
    done_acc_d = done_acc_q;
    update_d   = 1'b0;
    done_d     = '0;
    if ((state_q != StIdle) && tick_c) pending_d = 1'b1;
    case (state_q)
      StIdle: begin
        if (cfg_valid_i && chan_ok_c) begin
          tgt_d[cfg_chan_i]  = cfg_target_i;
          step_d[cfg_chan_i] = cfg_step_i;
        end
        if (tick_c || pending_q) begin
          state_d    = StSweep;
          idx_d      = '0;
          pending_d  = 1'b0;
          done_acc_d = '0;
        end
      end
      StSweep: begin
        cur_d[idx_q] = step_res_c;
        if ((sel_cur_c != sel_tgt_c) && (step_res_c == sel_tgt_c)) done_acc_d[idx_q] = 1'b1;
        if (last_c) begin
`ifdef PWM_FADE_SYNC_UPDATE_EN
          state_d  = StUpdate;
`else
          state_d  = StIdle;
          update_d = 1'b1;
          done_d   = done_acc_d;
`endif
        end else begin
          idx_d = idx_q + ChanW'(1);
        end
      end
`ifdef PWM_FADE_SYNC_UPDATE_EN
      StUpdate: begin
        state_d  = StIdle;
        update_d = 1'b1;
        done_d   = done_acc_q;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Busy flags track the register values about to be stored.
  always_comb begin
    busy_d = '0;
    for (int unsigned k = 0; k < NumChannels; k++) busy_d[k] = (cur_d[k] != tgt_d[k]);
  end

  // State and channel registers.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      tgt_q      <= '0;
      step_q     <= '0;
      cur_q      <= '0;
      done_acc_q <= '0;
      done_q     <= '0;
      busy_q     <= '0;
      update_q   <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      tgt_q      <= tgt_d;
      step_q     <= step_d;
      cur_q      <= cur_d;
      done_acc_q <= done_acc_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      update_q   <= update_d;
      ready_q    <= (state_d == StIdle);
    end
  end

`ifdef PWM_FADE_SYNC_UPDATE_EN
  logic [NumChannels-1:0][CtrSize-1:0] pw_q;

  // Shadow bank: all channels publish together in UPDATE.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) pw_q <= '0;
    else if (state_q == StUpdate) pw_q <= cur_q;
  end

  assign pulse_width_o = pw_q;
`else
  assign pulse_width_o = cur_q;
`endif

  assign cfg_ready_o = ready_q;
  assign update_o    = update_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
